// File: rtl/divisor_8bits.sv
// 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// A zero divisor skips the iterations and reports a saturated quotient.
`timescale 1ns/1ps
module divisor_8bits (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] A_i,
  input  logic [3:0] B_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       div_zero_o,
  output logic [7:0] Q_o,
  output logic [3:0] R_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [3:0]  rem_q, rem_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  q_q, q_d;
  logic [3:0]  r_q, r_d;
  logic        dz_q, dz_d;

  logic [4:0]  trial;
  logic        ge;
  logic [3:0]  rem_step;

  // The dividend register shifts left, so its MSB is always the next bit.
  assign trial    = {rem_q, a_q[7]};
  assign ge       = (trial >= {1'b0, b_q});
  // The difference is always below the divisor, so 4-bit wraparound is exact.
  assign rem_step = ge ? (trial[3:0] - b_q) : trial[3:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d   = A_i;
          b_d   = B_i;
          cnt_d = 3'd0;
          rem_d = 4'd0;
          quo_d = 8'd0;
          if (B_i == 4'd0) begin
            state_d = DONE;
            q_d     = 8'hFF;
            r_d     = 4'h0;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = rem_step;
        a_d   = {a_q[6:0], 1'b0};
        quo_d = {quo_q[6:0], ge};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          q_d     = {quo_q[6:0], ge};
          r_d     = rem_step;
          dz_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      a_q     <= 8'd0;
      b_q     <= 4'd0;
      rem_q   <= 4'd0;
      quo_q   <= 8'd0;
      q_q     <= 8'd0;
      r_q     <= 4'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o     = (state_q == DIV);
  assign done_o     = (state_q == DONE);
  assign Q_o        = q_q;
  assign R_o        = r_q;
  assign div_zero_o = dz_q;

endmodule
